// File: rtl/maj_pkg.sv
// Shared constants, stored-entry layout and popcount helper for the streaming
// 4-input majority voter.
package maj_pkg;

  localparam int W_DEF     = 4;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 16;

  // Stored entry: tie mask in the upper W bits, majority in the lower W bits.
  typedef struct packed {
    logic [W_DEF-1:0] tie;
    logic [W_DEF-1:0] maj;
  } entry_t;

  function automatic logic [2:0] popcnt4(input logic a, input logic b,
                                         input logic c, input logic d);
    popcnt4 = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction

endpackage

// File: rtl/majority_vote_stream_if.sv
// Operand and result valid/ready channels of the majority voter.
// The master side drives operands and consumes results; the slave side is the voter.
interface majority_vote_stream_if
  import maj_pkg::*;
#(
  parameter int W = W_DEF
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [W-1:0] out_tie;

  modport master (
    output in_valid, a, b, c, d, out_ready,
    input  in_ready, out_valid, out_data, out_tie
  );

  modport slave (
    input  in_valid, a, b, c, d, out_ready,
    output in_ready, out_valid, out_data, out_tie
  );

endinterface

// File: rtl/maj_fifo.sv
// Synchronous FIFO with synchronous flush, occupancy count and async active-low reset.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module maj_fifo #(
  parameter int PW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PW-1:0]              din,
  output logic [PW-1:0]              dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;

  assign push_s = push && !flush && (count_r < DEPTH_C);
  assign pop_s  = pop && !flush && (count_r != '0);

  // Pointer and occupancy tracking; flush empties the FIFO in one edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/majority_vote_stream.sv
// Streaming 4-input bitwise majority voter with tie mask and result FIFO.
// Optional MAJ_TIE_CNT_EN adds tie_cnt, counting accepts with a nonzero tie mask.
module majority_vote_stream
  import maj_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  flush,
  majority_vote_stream_if.slave bus,
  output logic [CNT_W-1:0]      vote_cnt
`ifdef MAJ_TIE_CNT_EN
  ,
  output logic [CNT_W-1:0]      tie_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]     maj_s;
  logic [W-1:0]     tie_s;
  logic [2:0]       n_s;
  logic [2*W-1:0]   head_s;
  logic [CW-1:0]    count_s;
  logic             ready_en_r;
  logic             in_ready_s;
  logic             accept_s;
  logic             pop_s;
  logic [CNT_W-1:0] vote_cnt_r;

  // Per-bit vote of the incoming operand set.
  always_comb begin
    maj_s = '0;
    tie_s = '0;
    n_s   = 3'd0;
    for (int i = 0; i < W; i++) begin
      n_s      = popcnt4(bus.a[i], bus.b[i], bus.c[i], bus.d[i]);
      maj_s[i] = (n_s >= 3'd3);
      tie_s[i] = (n_s == 3'd2);
    end
  end

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ready_en_r <= 1'b0;
    else        ready_en_r <= 1'b1;
  end

  // Ready depends on registered occupancy only, so a full FIFO refuses input even when popping.
  assign in_ready_s = ready_en_r && (count_s < DEPTH_C);
  assign accept_s   = bus.in_valid && in_ready_s && !flush;
  assign pop_s      = bus.out_valid && bus.out_ready;

  maj_fifo #(
    .PW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .flush (flush),
    .push  (accept_s),
    .pop   (pop_s),
    .din   ({tie_s, maj_s}),
    .dout  (head_s),
    .count (count_s)
  );

  // Accepted-vector counter; a flushed accept never reaches here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        vote_cnt_r <= '0;
    else if (accept_s) vote_cnt_r <= vote_cnt_r + CNT_W'(1);
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (count_s != '0);
  assign bus.out_data  = head_s[W-1:0];
  assign bus.out_tie   = head_s[2*W-1:W];
  assign vote_cnt      = vote_cnt_r;

`ifdef MAJ_TIE_CNT_EN
  logic [CNT_W-1:0] tie_cnt_r;

  // Counts accepts that carried at least one 2-of-4 tie; flush leaves it alone.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 tie_cnt_r <= '0;
    else if (accept_s && |tie_s) tie_cnt_r <= tie_cnt_r + CNT_W'(1);
  end

  assign tie_cnt = tie_cnt_r;
`endif

endmodule

// File: tb/tb_majority_vote_stream.sv
// Scoreboard bench for majority_vote_stream: directed operand sets with hand-computed
// results are queued on accept and checked by a monitor on each output handshake.
module tb_majority_vote_stream;
  import maj_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        flush;
  logic [15:0] vote_cnt;
`ifdef MAJ_TIE_CNT_EN
  logic [15:0] tie_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_votes = 0;
  int exp_ties = 0;
  logic [7:0] sb[$];

  majority_vote_stream_if #(.W(4)) bus ();

  majority_vote_stream #(.W(4), .DEPTH(4), .CNT_W(16)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .flush    (flush),
    .bus      (bus),
    .vote_cnt (vote_cnt)
`ifdef MAJ_TIE_CNT_EN
    ,
    .tie_cnt  (tie_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard head.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (RST_N && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data %0h tie %0h expected none", bus.out_data, bus.out_tie);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e[3:0]));
          chk("out_tie", 32'(bus.out_tie), 32'(e[7:4]));
        end
      end
    end
  end

  // Issue one operand set and wait (bounded) for its accept; returns just after the edge.
  task automatic push(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vc,
                      input logic [3:0] vd, input logic [3:0] em, input logic [3:0] et);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = va; bus.b = vb; bus.c = vc; bus.d = vd;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      ok = bus.in_ready;
      if (ok) begin
        sb.push_back({et, em});
        exp_votes++;
        if (et != 4'd0) exp_ties++;
      end
      @(posedge CLK);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && (sb.size() != 0 || bus.out_valid); k++) begin
      @(posedge CLK);
      #1;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = 4'd0; bus.b = 4'd0; bus.c = 4'd0; bus.d = 4'd0;
    bus.out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_tie", 32'(bus.out_tie), 32'd0);
    chk("rst_vote_cnt", 32'(vote_cnt), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Basic vote with one-cycle latency
    push(4'd12, 4'd4, 4'd14, 4'd0, 4'b0100, 4'b1000);
    chk("basic_out_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_out_data", 32'(bus.out_data), 32'h4);
    chk("basic_out_tie", 32'(bus.out_tie), 32'h8);
    chk("basic_vote_cnt", 32'(vote_cnt), 32'd1);
    drain();

    // Unanimous, all-zero and mixed patterns
    push(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
    push(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    push(4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0);
    push(4'h3, 4'h5, 4'h6, 4'h0, 4'h0, 4'h7);
    push(4'h7, 4'h7, 4'h7, 4'h8, 4'h7, 4'h0);
    drain();
    chk("mixed_vote_cnt", 32'(vote_cnt), 32'(exp_votes));

    // Backpressure: fill to DEPTH, fifth set held
    bus.out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) push(4'(v), 4'(v), 4'(v), 4'h0, 4'(v), 4'h0);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = 4'h5; bus.b = 4'h5; bus.c = 4'h0; bus.d = 4'h0;
    repeat (2) begin
      @(negedge CLK);
      chk("held_in_ready", 32'(bus.in_ready), 32'd0);
      chk("held_vote_cnt", 32'(vote_cnt), 32'(exp_votes));
    end
    @(posedge CLK);
    #1;
    // Full with simultaneous pop: no push this edge
    bus.out_ready = 1'b1;
    @(negedge CLK);
    chk("fullpop_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge CLK);
    #1;
    chk("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
    chk("after_pop_vote_cnt", 32'(vote_cnt), 32'(exp_votes));
    @(negedge CLK);
    chk("fifth_in_ready", 32'(bus.in_ready), 32'd1);
    sb.push_back({4'h5, 4'h0});
    exp_votes++;
    exp_ties++;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    chk("fifth_vote_cnt", 32'(vote_cnt), 32'(exp_votes));
    drain();

    // Flush with concurrent accept
    bus.out_ready = 1'b0;
    push(4'h9, 4'h9, 4'h6, 4'h6, 4'h0, 4'hF);
    push(4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF);
    bus.in_valid = 1'b1;
    bus.a = 4'hA; bus.b = 4'hA; bus.c = 4'hA; bus.d = 4'h5;
    flush = 1'b1;
    sb.delete();
    @(posedge CLK);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_vote_cnt", 32'(vote_cnt), 32'(exp_votes));
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef MAJ_TIE_CNT_EN
    chk("flush_tie_cnt", 32'(tie_cnt), 32'(exp_ties));
`endif
    bus.out_ready = 1'b1;
    push(4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h0);
    drain();

    // Async reset mid-stream, observed before any clock edge
    bus.out_ready = 1'b0;
    push(4'hC, 4'hC, 4'h3, 4'h3, 4'h0, 4'hF);
    push(4'hE, 4'hE, 4'hE, 4'h1, 4'hE, 4'h0);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_vote_cnt", 32'(vote_cnt), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_out_data", 32'(bus.out_data), 32'd0);
`ifdef MAJ_TIE_CNT_EN
    chk("arst_tie_cnt", 32'(tie_cnt), 32'd0);
`endif
    sb.delete();
    exp_votes = 0;
    exp_ties = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    push(4'hE, 4'hE, 4'h1, 4'h1, 4'h0, 4'hF);
    chk("post_rst_vote_cnt", 32'(vote_cnt), 32'd1);
`ifdef MAJ_TIE_CNT_EN
    chk("post_rst_tie_cnt", 32'(tie_cnt), 32'(exp_ties));
`endif
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
